// File: rtl/cal_pulse_seq.sv
// cal_pulse_seq: calibration run sequencer feeding the calibration trigger block.
// Issues a train of single-cycle requests (CCBINJ/CCBPLS/PRELCT/PREGTRG), waits for
// each acknowledge (CAL_GTRG, or CALLCT_1 in LCT mode), spaces the next request,
// counts acknowledged events and flags timeouts.
// Ports:
//   CLKCMS, RST          clock, synchronous active-high reset
//   START, STOP          run start (acted on in IDLE) / run abort
//   MODE, NPULSE, SPACING run configuration, latched at run start
//   CAL_GTRG, CALLCT_1   acknowledges
//   CCBINJ..PREGTRG      one-cycle request strobes
//   BUSY, DONE, TMO_ERR, EVCNT  run status

// Up-counter with synchronous clear; optional triplicated storage with majority vote.
module cal_pulse_seq_cnt #(
    parameter int unsigned W   = 8,
    parameter int unsigned TMR = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);
    logic [W-1:0] w_next;

    always_comb begin
        w_next = o_q;
        if (i_clr) begin
            w_next = '0;
        end else if (i_inc) begin
            w_next = o_q + W'(1);
        end
    end

    generate
        if (TMR != 0) begin : g_tmr
            logic [W-1:0] r_a;
            logic [W-1:0] r_b;
            logic [W-1:0] r_c;
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_a <= '0;
                    r_b <= '0;
                    r_c <= '0;
                end else begin
                    r_a <= w_next;
                    r_b <= w_next;
                    r_c <= w_next;
                end
            end
            assign o_q = (r_a & r_b) | (r_a & r_c) | (r_b & r_c);
        end else begin : g_plain
            logic [W-1:0] r_q;
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_q <= '0;
                end else begin
                    r_q <= w_next;
                end
            end
            assign o_q = r_q;
        end
    endgenerate
endmodule

module cal_pulse_seq #(
    parameter int unsigned TMR     = 0,
    parameter int unsigned TMO_CYC = 2047
) (
    input  logic        CLKCMS,
    input  logic        RST,
    input  logic        START,
    input  logic        STOP,
    input  logic [1:0]  MODE,
    input  logic [9:0]  NPULSE,
    input  logic [15:0] SPACING,
    input  logic        CAL_GTRG,
    input  logic        CALLCT_1,
    output logic        CCBINJ,
    output logic        CCBPLS,
    output logic        PRELCT,
    output logic        PREGTRG,
    output logic        BUSY,
    output logic        DONE,
    output logic        TMO_ERR,
    output logic [9:0]  EVCNT
);
    localparam int unsigned EVW = 10;
    localparam int unsigned WTW = 11;
    localparam int unsigned GPW = 16;
    localparam logic [WTW-1:0] TMO_LAST = WTW'(TMO_CYC - 1);
    localparam logic [EVW-1:0] EV_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t         w_state;
    state_t         w_nstate;
    logic [1:0]     r_mode;
    logic [EVW-1:0] r_npulse;
    logic [GPW-1:0] r_spacing;
    logic [3:0]     r_strb;
    logic           r_busy;
    logic           r_done;
    logic           r_tmo;

    logic [EVW-1:0] w_issue;
    logic [WTW-1:0] w_wait;
    logic [GPW-1:0] w_gap;
    logic [EVW-1:0] w_evcnt;
    logic w_issue_clr, w_issue_inc, w_wait_clr, w_wait_inc;
    logic w_gap_clr, w_gap_inc, w_ev_clr, w_ev_inc;
    logic w_run_start, w_fire, w_tmo_set;
    logic w_ack, w_tmo, w_last;

    // State register, optionally triplicated with bitwise vote
    generate
        if (TMR != 0) begin : g_st_tmr
            logic [2:0] r_st_a;
            logic [2:0] r_st_b;
            logic [2:0] r_st_c;
            always_ff @(posedge CLKCMS) begin
                if (RST) begin
                    r_st_a <= S_IDLE;
                    r_st_b <= S_IDLE;
                    r_st_c <= S_IDLE;
                end else begin
                    r_st_a <= w_nstate;
                    r_st_b <= w_nstate;
                    r_st_c <= w_nstate;
                end
            end
            assign w_state = state_t'((r_st_a & r_st_b) | (r_st_a & r_st_c) | (r_st_b & r_st_c));
        end else begin : g_st_plain
            state_t r_state;
            always_ff @(posedge CLKCMS) begin
                if (RST) begin
                    r_state <= S_IDLE;
                end else begin
                    r_state <= w_nstate;
                end
            end
            assign w_state = r_state;
        end
    endgenerate

    // Acknowledge source follows the latched mode; the wait counter starts at 0 on the
    // first WAIT edge, so TMO_LAST is hit exactly TMO_CYC edges after the strobe edge.
    assign w_ack  = (r_mode == 2'b10) ? CALLCT_1 : CAL_GTRG;
    assign w_tmo  = (w_wait == TMO_LAST);
    assign w_last = (r_npulse != '0) && (w_issue == r_npulse);

    // Next-state and counter control
    always_comb begin
        w_nstate    = w_state;
        w_issue_clr = 1'b0;
        w_issue_inc = 1'b0;
        w_wait_clr  = 1'b0;
        w_wait_inc  = 1'b0;
        w_gap_clr   = 1'b0;
        w_gap_inc   = 1'b0;
        w_ev_clr    = 1'b0;
        w_ev_inc    = 1'b0;
        w_run_start = 1'b0;
        w_fire      = 1'b0;
        w_tmo_set   = 1'b0;
        case (w_state)
            S_IDLE: begin
                if (START && !STOP) begin
                    w_nstate    = S_ISSUE;
                    w_run_start = 1'b1;
                    w_issue_clr = 1'b1;
                    w_ev_clr    = 1'b1;
                end
            end
            S_ISSUE: begin
                if (STOP) begin
                    w_nstate = S_FIN;
                end else begin
                    w_nstate    = S_WAIT;
                    w_fire      = 1'b1;
                    w_issue_inc = 1'b1;
                    w_wait_clr  = 1'b1;
                end
            end
            S_WAIT: begin
                w_wait_inc = 1'b1;
                w_ev_inc   = w_ack && (w_evcnt != EV_MAX);
                w_tmo_set  = w_tmo && !w_ack;
                if (STOP) begin
                    w_nstate = S_FIN;
                end else if (w_ack || w_tmo) begin
                    if (w_last) begin
                        w_nstate = S_FIN;
                    end else if (r_spacing == '0) begin
                        w_nstate = S_ISSUE;
                    end else begin
                        w_nstate  = S_GAP;
                        w_gap_clr = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (STOP) begin
                    w_nstate = S_FIN;
                end else if (w_gap == (r_spacing - GPW'(1))) begin
                    w_nstate = S_ISSUE;
                end else begin
                    w_gap_inc = 1'b1;
                end
            end
            S_FIN: begin
                w_nstate = S_IDLE;
            end
            default: begin
                w_nstate = S_IDLE;
            end
        endcase
    end

    cal_pulse_seq_cnt #(.W(EVW), .TMR(TMR)) u_issue_cnt (
        .i_clk(CLKCMS), .i_rst(RST), .i_clr(w_issue_clr), .i_inc(w_issue_inc), .o_q(w_issue)
    );
    cal_pulse_seq_cnt #(.W(WTW), .TMR(TMR)) u_wait_cnt (
        .i_clk(CLKCMS), .i_rst(RST), .i_clr(w_wait_clr), .i_inc(w_wait_inc), .o_q(w_wait)
    );
    cal_pulse_seq_cnt #(.W(GPW), .TMR(TMR)) u_gap_cnt (
        .i_clk(CLKCMS), .i_rst(RST), .i_clr(w_gap_clr), .i_inc(w_gap_inc), .o_q(w_gap)
    );
    cal_pulse_seq_cnt #(.W(EVW), .TMR(TMR)) u_ev_cnt (
        .i_clk(CLKCMS), .i_rst(RST), .i_clr(w_ev_clr), .i_inc(w_ev_inc), .o_q(w_evcnt)
    );

    // Configuration latch and registered outputs (status follows the next state)
    always_ff @(posedge CLKCMS) begin
        if (RST) begin
            r_mode    <= '0;
            r_npulse  <= '0;
            r_spacing <= '0;
            r_strb    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_tmo     <= 1'b0;
        end else begin
            if (w_run_start) begin
                r_mode    <= MODE;
                r_npulse  <= NPULSE;
                r_spacing <= SPACING;
            end
            r_strb <= w_fire ? (4'b0001 << r_mode) : 4'b0000;
            r_busy <= (w_nstate == S_ISSUE) || (w_nstate == S_WAIT) || (w_nstate == S_GAP);
            r_done <= (w_nstate == S_FIN);
            if (w_run_start) begin
                r_tmo <= 1'b0;
            end else if (w_tmo_set) begin
                r_tmo <= 1'b1;
            end
        end
    end

    assign CCBINJ  = r_strb[0];
    assign CCBPLS  = r_strb[1];
    assign PRELCT  = r_strb[2];
    assign PREGTRG = r_strb[3];
    assign BUSY    = r_busy;
    assign DONE    = r_done;
    assign TMO_ERR = r_tmo;
    assign EVCNT   = w_evcnt;
endmodule

// File: tb/tb_cal_pulse_seq.sv
// Testbench for cal_pulse_seq: acknowledge responder plus an event-timing model that
// predicts strobe edges, DONE edge, event count and timeout flag from run parameters.
module tb_cal_pulse_seq;
    localparam int TMO = 2047;

    logic        CLKCMS = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        STOP = 1'b0;
    logic [1:0]  MODE = '0;
    logic [9:0]  NPULSE = '0;
    logic [15:0] SPACING = '0;
    logic        CAL_GTRG = 1'b0;
    logic        CALLCT_1 = 1'b0;
    logic        CCBINJ, CCBPLS, PRELCT, PREGTRG, BUSY, DONE, TMO_ERR;
    logic [9:0]  EVCNT;

    cal_pulse_seq #(.TMR(0), .TMO_CYC(TMO)) dut (
        .CLKCMS(CLKCMS), .RST(RST), .START(START), .STOP(STOP),
        .MODE(MODE), .NPULSE(NPULSE), .SPACING(SPACING),
        .CAL_GTRG(CAL_GTRG), .CALLCT_1(CALLCT_1),
        .CCBINJ(CCBINJ), .CCBPLS(CCBPLS), .PRELCT(PRELCT), .PREGTRG(PREGTRG),
        .BUSY(BUSY), .DONE(DONE), .TMO_ERR(TMO_ERR), .EVCNT(EVCNT)
    );

    always #5 CLKCMS = ~CLKCMS;

    int cyc = 0;
    always @(posedge CLKCMS) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Observed activity and responder settings
    int strb_cyc[$];
    int strb_id[$];
    int done_cnt = 0;
    int done_cyc = -1;
    int viol = 0;
    bit prev_any = 1'b0;
    int ack_due = -1000;
    bit resp_en = 1'b0;
    bit resp_lct = 1'b0;
    bit noise_en = 1'b0;
    int resp_l = 1;
    logic [3:0] mon_s;
    int mon_id;
    bit ack_v;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor strobes/DONE and drive acknowledges L edges after each strobe edge
    always @(negedge CLKCMS) begin
        mon_s = {PREGTRG, PRELCT, CCBPLS, CCBINJ};
        if (mon_s != 4'b0000) begin
            if (prev_any) viol++;
            if (!$onehot(mon_s)) viol++;
            mon_id = 0;
            for (int i = 0; i < 4; i++) if (mon_s[i]) mon_id = i;
            strb_cyc.push_back(cyc);
            strb_id.push_back(mon_id);
            ack_due = cyc + resp_l;
        end
        prev_any = (mon_s != 4'b0000);
        if (DONE === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (BUSY !== 1'b0) viol++;
        end
        ack_v = resp_en && (cyc + 1 == ack_due);
        if (resp_lct) begin
            CALLCT_1 = ack_v;
            CAL_GTRG = noise_en ? 1'($urandom) : 1'b0;
        end else begin
            CAL_GTRG = ack_v;
            CALLCT_1 = noise_en ? 1'($urandom) : 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge CLKCMS);
            #1;
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int b;
        b = budget;
        while (done_cnt < target && b > 0) begin
            step(1);
            b--;
        end
        if (done_cnt < target) chk("wait_done", done_cnt, target);
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int b;
        b = budget;
        while (strb_cyc.size() < target && b > 0) begin
            step(1);
            b--;
        end
        if (strb_cyc.size() < target) chk("wait_strobes", strb_cyc.size(), target);
    endtask

    function automatic int strb_at(input int idx);
        return (idx < strb_cyc.size()) ? strb_cyc[idx] : -1;
    endfunction

    function automatic int id_at(input int idx);
        return (idx < strb_id.size()) ? strb_id[idx] : -1;
    endfunction

    // One finite run with a fixed latency (or no acknowledge) for every event
    task automatic run_plain(input int mode, input int n, input int sp, input int lat,
                             input bit ack_on, input bit noise);
        int bs, bd, s0, leff, per, exp_done, v0;
        resp_lct = (mode == 2);
        resp_en  = ack_on;
        resp_l   = lat;
        noise_en = noise;
        bs = strb_cyc.size();
        bd = done_cnt;
        v0 = viol;
        MODE = 2'(mode);
        NPULSE = 10'(n);
        SPACING = 16'(sp);
        START = 1'b1;
        s0 = cyc + 2;
        step(1);
        START = 1'b0;
        MODE = 2'($urandom);
        NPULSE = 10'($urandom);
        SPACING = 16'($urandom);
        leff = ack_on ? lat : TMO;
        per = leff + sp + 1;
        exp_done = s0 + (n - 1) * per + leff;
        wait_done(bd + 1, n * per + 50);
        step(4);
        chk("strobe_count", strb_cyc.size() - bs, n);
        for (int k = 0; k < n; k++) begin
            chk("strobe_cycle", strb_at(bs + k), s0 + k * per);
            chk("strobe_kind", id_at(bs + k), mode);
        end
        chk("done_count", done_cnt - bd, 1);
        chk("done_cycle", done_cyc, exp_done);
        chk("evcnt", int'(EVCNT), ack_on ? n : 0);
        chk("tmo_err", int'(TMO_ERR), ack_on ? 0 : 1);
        chk("busy_after", int'(BUSY), 0);
        chk("protocol_viol", viol - v0, 0);
        noise_en = 1'b0;
    endtask

    int bs, bd, s, d;

    initial begin
        // Reset state
        step(3);
        chk("rst_outputs", int'({CCBINJ, CCBPLS, PRELCT, PREGTRG, BUSY, DONE, TMO_ERR}), 0);
        chk("rst_evcnt", int'(EVCNT), 0);
        RST = 1'b0;
        step(2);

        // Inject run, LCT run with noise on the unused acknowledge, timeout, same-edge ack
        run_plain(0, 3, 10, 130, 1'b1, 1'b0);
        run_plain(2, 2, 0, 20, 1'b1, 1'b1);
        run_plain(1, 2, 5, 0, 1'b0, 1'b0);
        run_plain(1, 1, 5, TMO, 1'b1, 1'b0);

        // Randomized finite runs
        for (int r = 0; r < 8; r++) begin
            run_plain(int'($urandom_range(3, 0)), int'($urandom_range(4, 1)),
                      int'($urandom_range(20, 0)), int'($urandom_range(40, 1)),
                      1'b1, 1'($urandom));
            step(int'($urandom_range(5, 1)));
        end

        // Free run, abort during GAP
        resp_lct = 1'b0; resp_en = 1'b1; resp_l = 10;
        bs = strb_cyc.size(); bd = done_cnt;
        MODE = 2'b11; NPULSE = '0; SPACING = 16'd3; START = 1'b1;
        step(1);
        START = 1'b0;
        wait_strobes(bs + 5, 200);
        s = strb_at(strb_cyc.size() - 1);
        while (cyc < s + 11) step(1);
        STOP = 1'b1;
        step(1);
        STOP = 1'b0;
        step(30);
        chk("free_strobes", strb_cyc.size() - bs, 5);
        for (int k = 1; k < 5; k++) chk("free_period", strb_at(bs + k) - strb_at(bs + k - 1), 14);
        chk("free_kind", id_at(bs + 4), 3);
        chk("abort_done_cycle", done_cyc, s + 12);
        chk("abort_done_count", done_cnt - bd, 1);
        chk("abort_evcnt", int'(EVCNT), 5);

        // Reset in WAIT_ACK after one acknowledged event
        resp_l = 50;
        bs = strb_cyc.size(); bd = done_cnt;
        MODE = 2'b00; NPULSE = 10'd3; SPACING = 16'd2; START = 1'b1;
        step(1);
        START = 1'b0;
        wait_strobes(bs + 2, 200);
        step(20);
        chk("pre_rst_evcnt", int'(EVCNT), 1);
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        chk("midrst_outputs", int'({CCBINJ, CCBPLS, PRELCT, PREGTRG, BUSY, DONE, TMO_ERR}), 0);
        chk("midrst_evcnt", int'(EVCNT), 0);
        step(80);
        chk("midrst_no_strobe", strb_cyc.size() - bs, 2);
        chk("midrst_no_done", done_cnt - bd, 0);
        START = 1'b1; STOP = 1'b1;
        step(10);
        START = 1'b0; STOP = 1'b0;
        chk("startstop_idle", strb_cyc.size() - bs, 2);
        chk("startstop_busy", int'(BUSY), 0);

        // START held across run end re-arms as soon as IDLE is re-entered
        resp_l = 5;
        bs = strb_cyc.size(); bd = done_cnt;
        MODE = 2'b01; NPULSE = 10'd2; SPACING = 16'd1; START = 1'b1;
        s = cyc + 2;
        wait_done(bd + 1, 100);
        d = done_cyc;
        wait_strobes(bs + 3, 20);
        START = 1'b0;
        chk("held_first", strb_at(bs), s);
        chk("held_period", strb_at(bs + 1) - strb_at(bs), 7);
        chk("held_restart", strb_at(bs + 2), d + 3);
        wait_done(bd + 2, 100);
        step(2);
        chk("held_evcnt", int'(EVCNT), 2);
        chk("held_tmo", int'(TMO_ERR), 0);

        // EVCNT saturation in free run, stopped on an ISSUE edge
        resp_l = 1;
        bs = strb_cyc.size(); bd = done_cnt;
        MODE = 2'b00; NPULSE = '0; SPACING = '0; START = 1'b1;
        step(1);
        START = 1'b0;
        wait_strobes(bs + 1100, 2400);
        step(1);
        STOP = 1'b1;
        step(1);
        STOP = 1'b0;
        step(10);
        chk("sat_strobes", strb_cyc.size() - bs, 1100);
        chk("sat_period", strb_at(bs + 1099) - strb_at(bs + 1098), 2);
        chk("sat_evcnt", int'(EVCNT), 1023);
        chk("sat_done", done_cnt - bd, 1);
        chk("final_viol", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
